// File: rtl/mdu_ctrl_if.sv
// Bundle of EX-stage request, D-stage hazard query and result signals for the multiply/divide unit.
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    // Pipeline side: issues operations and watches busy/stall/HI/LO.
    modport master (
        output start, op, a, b, md_use_d,
        input  busy, stall_md, hi, lo
    );

    // Unit side.
    modport slave (
        input  start, op, a, b, md_use_d,
        output busy, stall_md, hi, lo
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit: computes the result when the op is accepted,
// parks it in pending registers and commits it to HI/LO after a fixed busy latency.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    mdu_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic [31:0]        hi_reg;
    logic [31:0]        lo_reg;
    logic [31:0]        pend_hi_reg;
    logic [31:0]        pend_lo_reg;

    // op 0..3 are the long-latency arithmetic ops
    logic is_arith;
    assign is_arith = bus.start & ~bus.op[2];

    // Products: the low 64 bits of a 64x64 product of sign-/zero-extended
    // operands equal the signed/unsigned 32x32 product.
    logic [63:0] a_sx, b_sx, smul, umul;
    assign a_sx = {{32{bus.a[31]}}, bus.a};
    assign b_sx = {{32{bus.b[31]}}, bus.b};
    assign smul = a_sx * b_sx;
    assign umul = {32'd0, bus.a} * {32'd0, bus.b};

    // Division on magnitudes, then sign fix-up. 0x80000000 / -1 falls out
    // naturally as 0x80000000 rem 0, so no special case is needed.
    logic        div_signed;
    logic        a_neg, b_neg, b_zero;
    logic [31:0] mag_a, mag_b, mag_b_safe, quot_mag, rem_mag, quot, rem;
    assign div_signed = (bus.op[1:0] == 2'd2);
    assign a_neg      = div_signed & bus.a[31];
    assign b_neg      = div_signed & bus.b[31];
    assign b_zero     = (bus.b == 32'd0);
    assign mag_a      = a_neg ? (~bus.a + 32'd1) : bus.a;
    assign mag_b      = b_neg ? (~bus.b + 32'd1) : bus.b;
    assign mag_b_safe = b_zero ? 32'd1 : mag_b;
    assign quot_mag   = mag_a / mag_b_safe;
    assign rem_mag    = mag_a % mag_b_safe;
    assign quot       = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
    assign rem        = a_neg ? (~rem_mag + 32'd1) : rem_mag;

    // Select the result to park; divide-by-zero parks the current HI/LO so
    // the commit leaves them unchanged.
    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = hi_reg;
        res_lo = lo_reg;
        case (bus.op[1:0])
            2'd0: begin
                res_hi = smul[63:32];
                res_lo = smul[31:0];
            end
            2'd1: begin
                res_hi = umul[63:32];
                res_lo = umul[31:0];
            end
            default: begin
                if (!b_zero) begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
        endcase
    end

    // Sequencing FSM with HI/LO, pending result and down-counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (is_arith) begin
                        pend_hi_reg <= res_hi;
                        pend_lo_reg <= res_lo;
                        cnt_reg     <= bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_reg    <= 1'b1;
                        state_reg   <= BUSY;
                    end else if (bus.start && bus.op == 3'd4) begin
                        hi_reg <= bus.a;
                    end else if (bus.start && bus.op == 3'd5) begin
                        lo_reg <= bus.a;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        hi_reg    <= pend_hi_reg;
                        lo_reg    <= pend_lo_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.hi       = hi_reg;
    assign bus.lo       = lo_reg;
    // Freeze a D-stage MDU instruction while an op is in flight or being issued now
    assign bus.stall_md = bus.md_use_d & (busy_reg | is_arith);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus stall and reset sequences.
module tb_mdu_ctrl;

    logic clk;
    logic reset_n;

    mdu_ctrl_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    int total_checks = 0;
    int pass_checks  = 0;

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] eh, input logic [31:0] el, input int cyc,
                                input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b;
        v.exp_hi = eh; v.exp_lo = el; v.exp_cycles = cyc; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) pass_checks++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Issue one op, count busy cycles, then compare against the scoreboard entry.
    task automatic run_vec(input vec_t v);
        logic [31:0] old_hi, old_lo;
        int          cnt;
        logic        hold_ok;
        exp_t        e;
        old_hi = bus.hi;
        old_lo = bus.lo;
        bus.start = 1'b1;
        bus.op    = v.op;
        bus.a     = v.a;
        bus.b     = v.b;
        sb.push_back('{v.exp_hi, v.exp_lo, v.exp_cycles, v.name});
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        hold_ok = 1'b1;
        while (bus.busy && cnt < 40) begin
            cnt++;
            if (bus.hi !== old_hi || bus.lo !== old_lo) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        check({e.name, "_cycles"}, 32'(cnt), 32'(e.cycles));
        if (e.cycles > 0) check({e.name, "_hold"}, {31'd0, hold_ok}, 32'd1);
        check({e.name, "_hi"}, bus.hi, e.hi);
        check({e.name, "_lo"}, bus.lo, e.lo);
        $display("txn %-10s op=%0d a=%08h b=%08h busy_cycles=%0d hi=%08h lo=%08h",
                 e.name, v.op, v.a, v.b, cnt, bus.hi, bus.lo);
    endtask

    initial begin
        int   cnt;
        logic stall_ok;
        exp_t e;

        vecs[0]  = mk(3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult_neg");
        vecs[1]  = mk(3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5,  "multu");
        vecs[2]  = mk(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg");
        vecs[3]  = mk(3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10, "divu_zero");
        vecs[4]  = mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10, "div_ovf");
        vecs[5]  = mk(3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10, "divu");
        vecs[6]  = mk(3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h0000000E, 0,  "mthi");
        vecs[7]  = mk(3'd5, 32'h000000AB, 32'd0,        32'h12345678, 32'h000000AB, 0,  "mtlo");
        vecs[8]  = mk(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5,  "mult_mix");
        vecs[9]  = mk(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10, "div_negb");
        vecs[10] = mk(3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 10, "div_both");
        vecs[11] = mk(3'd6, 32'hDEADBEEF, 32'd1,        32'hFFFFFFFE, 32'h00000002, 0,  "nop");
        vecs[12] = mk(3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5,  "multu_big");

        bus.start    = 1'b0;
        bus.op       = 3'd7;
        bus.a        = '0;
        bus.b        = '0;
        bus.md_use_d = 1'b0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, bus.busy},     32'd0);
        check("rst_hi",    bus.hi,                32'd0);
        check("rst_lo",    bus.lo,                32'd0);
        check("rst_stall", {31'd0, bus.stall_md}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Stall sequence: stall asserted at issue and throughout busy, a start
        // during busy is ignored, and stall drops in the cycle busy falls.
        bus.md_use_d = 1'b1;
        bus.start    = 1'b1;
        bus.op       = 3'd0;
        bus.a        = 32'd3;
        bus.b        = 32'd4;
        sb.push_back('{32'd0, 32'd12, 5, "stall_seq"});
        #1;
        check("stall_issue", {31'd0, bus.stall_md}, 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cnt = 0;
        stall_ok = 1'b1;
        while (bus.busy && cnt < 40) begin
            cnt++;
            bus.start = 1'b0;
            if (!bus.stall_md) stall_ok = 1'b0;
            if (cnt == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'd2;
                bus.a     = 32'd100;
                bus.b     = 32'd5;
            end
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        check("stall_busy",   {31'd0, stall_ok},     32'd1);
        check("stall_cycles", 32'(cnt),              32'(e.cycles));
        check("stall_fall",   {31'd0, bus.stall_md}, 32'd0);
        check("stall_hi",     bus.hi,                e.hi);
        check("stall_lo",     bus.lo,                e.lo);
        repeat (12) @(posedge clk);
        #1;
        check("ignored_busy", {31'd0, bus.busy}, 32'd0);
        check("ignored_hi",   bus.hi,            32'd0);
        check("ignored_lo",   bus.lo,            32'd12);
        $display("txn stall_seq  busy_cycles=%0d stall_ok=%0d hi=%08h lo=%08h", cnt, stall_ok, bus.hi, bus.lo);
        bus.md_use_d = 1'b0;

        // Asynchronous reset in the middle of a DIV.
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_hi",   bus.hi,            32'd0);
        check("arst_lo",   bus.lo,            32'd0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle", {31'd0, bus.busy}, 32'd0);
        $display("txn arst_div   busy=%0d hi=%08h lo=%08h", bus.busy, bus.hi, bus.lo);
        run_vec(mk(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, "mult_post"));

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
